// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the byte FIFO and its bench.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Pointers need at least one bit even for the smallest legal depth.
  function automatic int ptr_bits(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/byte_fifo.sv
// Show-ahead synchronous FIFO with sticky overflow flag; pointers wrap for any depth.
module byte_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               d,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WIDTH-1:0]               q,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [count_bits(DEPTH)-1:0]   count,
  output logic                           full,
  output logic                           empty,
  output logic                           ovf
);

  localparam int PW = ptr_bits(DEPTH);
  localparam int CW = count_bits(DEPTH);

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = r_count;
  assign ovf       = r_ovf;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // Stale storage stays hidden whenever the queue is empty, including right after reset.
  assign q         = empty ? '0 : w_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= next_ptr(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (in_valid && full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (PW)
  ) u_mem (
    .clk  (clk),
    .we   (w_push),
    .waddr(r_wptr),
    .wdata(d),
    .raddr(r_rptr),
    .rdata(w_rdata)
  );

endmodule

// File: tb/tb_byte_fifo.sv
// Directed bench for byte_fifo at DEPTH=4 and DEPTH=3.
module tb_byte_fifo;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic [7:0] d4, q4;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, full4, empty4, ovf4;
  logic [2:0] count4;

  logic [7:0] d3, q3;
  logic       in_valid3, in_ready3, out_valid3, out_ready3, full3, empty3, ovf3;
  logic [1:0] count3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_fifo #(.WIDTH(DEFAULT_WIDTH), .DEPTH(DEFAULT_DEPTH)) dut4 (
    .clk(clk), .reset(reset), .d(d4), .in_valid(in_valid4), .in_ready(in_ready4),
    .q(q4), .out_valid(out_valid4), .out_ready(out_ready4), .count(count4),
    .full(full4), .empty(empty4), .ovf(ovf4)
  );

  byte_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .d(d3), .in_valid(in_valid3), .in_ready(in_ready3),
    .q(q3), .out_valid(out_valid3), .out_ready(out_ready3), .count(count3),
    .full(full3), .empty(empty3), .ovf(ovf3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({count4, empty4, full4, in_ready4, out_valid4, q4, ovf4} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b ir=%b ov=%b q=%h ovf=%b, expected cnt=0 e=1 f=0 ir=1 ov=0 q=00 ovf=0",
               count4, empty4, full4, in_ready4, out_valid4, q4, ovf4);
    end
    checks++;
    if ({count3, empty3, out_valid3, q3} !== {2'd0, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state_d3: got cnt=%0d e=%b ov=%b q=%h, expected cnt=0 e=1 ov=0 q=00", count3, empty3, out_valid3, q3);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_first_push();
    d4 = 8'h01;
    in_valid4 = 1'b1;
    #1;
    checks++;
    if (out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: out_valid got %b expected 0", out_valid4);
    end
    tick();
    in_valid4 = 1'b0;
    $display("push 01 -> q=%h count=%0d", q4, count4);
    checks++;
    if ({q4, out_valid4, count4, empty4} !== {8'h01, 1'b1, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL first_push: got q=%h ov=%b cnt=%0d e=%b, expected q=01 ov=1 cnt=1 e=0", q4, out_valid4, count4, empty4);
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    checks++;
    if ({empty4, count4, q4} !== {1'b1, 3'd0, 8'h00}) begin
      errors++;
      $display("FAIL first_pop: got e=%b cnt=%0d q=%h, expected e=1 cnt=0 q=00", empty4, count4, q4);
    end
  endtask

  task automatic test_full_ovf();
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    in_valid4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d4 = words[i];
      tick();
      $display("push %h -> count=%0d", words[i], count4);
    end
    checks++;
    if ({full4, in_ready4, count4, ovf4} !== {1'b1, 1'b0, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL fill: got f=%b ir=%b cnt=%0d ovf=%b, expected f=1 ir=0 cnt=4 ovf=0", full4, in_ready4, count4, ovf4);
    end
    d4 = 8'h55;
    tick();
    checks++;
    if ({ovf4, count4, q4} !== {1'b1, 3'd4, 8'h11}) begin
      errors++;
      $display("FAIL overflow: got ovf=%b cnt=%0d q=%h, expected ovf=1 cnt=4 q=11", ovf4, count4, q4);
    end
    // Pop while full with a push pending: the push must still be refused.
    d4 = 8'h66;
    out_ready4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    checks++;
    if ({count4, q4} !== {3'd3, 8'h22}) begin
      errors++;
      $display("FAIL pop_when_full: got cnt=%0d q=%h, expected cnt=3 q=22", count4, q4);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (q4 !== words[i]) begin
        errors++;
        $display("FAIL drain_%0d: q got %h expected %h", i, q4, words[i]);
      end
      $display("pop %h", q4);
      tick();
    end
    out_ready4 = 1'b0;
    checks++;
    if ({empty4, count4, ovf4} !== {1'b1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL drained: got e=%b cnt=%0d ovf=%b, expected e=1 cnt=0 ovf=1", empty4, count4, ovf4);
    end
  endtask

  task automatic test_async_reset();
    in_valid4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d4 = 8'hA1 + 8'(i);
      tick();
    end
    in_valid4 = 1'b0;
    checks++;
    if ({count4, ovf4} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: got cnt=%0d ovf=%b, expected cnt=3 ovf=1", count4, ovf4);
    end
    #3;
    reset = 1'b1;
    #1;
    $display("async reset asserted between edges");
    checks++;
    if ({count4, empty4, full4, in_ready4, out_valid4, q4, ovf4} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d e=%b f=%b ir=%b ov=%b q=%h ovf=%b, expected cnt=0 e=1 f=0 ir=1 ov=0 q=00 ovf=0",
               count4, empty4, full4, in_ready4, out_valid4, q4, ovf4);
    end
    #1;
    reset = 1'b0;
    d4 = 8'h5A;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    checks++;
    if ({q4, count4} !== {8'h5A, 3'd1}) begin
      errors++;
      $display("FAIL post_reset_push: got q=%h cnt=%0d, expected q=5a cnt=1", q4, count4);
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    checks++;
    if (empty4 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_pop: empty got %b expected 1", empty4);
    end
  endtask

  task automatic test_back_to_back();
    in_valid4 = 1'b1;
    d4 = 8'h80;
    tick();
    d4 = 8'h81;
    tick();
    out_ready4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d4 = 8'h82 + 8'(i);
      checks++;
      if (q4 !== 8'h80 + 8'(i)) begin
        errors++;
        $display("FAIL b2b_q_%0d: q got %h expected %h", i, q4, 8'h80 + 8'(i));
      end
      tick();
      $display("b2b cycle %0d: push %h pop %h count=%0d", i, 8'h82 + 8'(i), 8'h80 + 8'(i), count4);
      checks++;
      if (count4 !== 3'd2) begin
        errors++;
        $display("FAIL b2b_count_%0d: count got %0d expected 2", i, count4);
      end
    end
    in_valid4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (q4 !== 8'h8A + 8'(i)) begin
        errors++;
        $display("FAIL b2b_drain_%0d: q got %h expected %h", i, q4, 8'h8A + 8'(i));
      end
      tick();
    end
    out_ready4 = 1'b0;
    checks++;
    if (empty4 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_empty: empty got %b expected 1", empty4);
    end
  endtask

  task automatic test_empty_pop();
    out_ready4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({count4, out_valid4, q4} !== {3'd0, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL empty_pop_%0d: got cnt=%0d ov=%b q=%h, expected cnt=0 ov=0 q=00", i, count4, out_valid4, q4);
      end
    end
    out_ready4 = 1'b0;
  endtask

  task automatic test_depth3_wrap();
    logic [7:0] words [7] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    in_valid3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d3 = words[i];
      tick();
    end
    in_valid3 = 1'b0;
    checks++;
    if ({full3, count3, q3} !== {1'b1, 2'd3, 8'hC0}) begin
      errors++;
      $display("FAIL d3_full: got f=%b cnt=%0d q=%h, expected f=1 cnt=3 q=c0", full3, count3, q3);
    end
    for (int k = 3; k < 7; k++) begin
      checks++;
      if (q3 !== words[k-3]) begin
        errors++;
        $display("FAIL d3_order_%0d: q got %h expected %h", k - 3, q3, words[k-3]);
      end
      $display("d3 pop %h", q3);
      out_ready3 = 1'b1;
      tick();
      out_ready3 = 1'b0;
      d3 = words[k];
      in_valid3 = 1'b1;
      tick();
      in_valid3 = 1'b0;
    end
    out_ready3 = 1'b1;
    for (int k = 4; k < 7; k++) begin
      checks++;
      if (q3 !== words[k]) begin
        errors++;
        $display("FAIL d3_order_%0d: q got %h expected %h", k, q3, words[k]);
      end
      $display("d3 pop %h", q3);
      tick();
    end
    out_ready3 = 1'b0;
    checks++;
    if ({empty3, count3, ovf3} !== {1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL d3_empty: got e=%b cnt=%0d ovf=%b, expected e=1 cnt=0 ovf=0", empty3, count3, ovf3);
    end
  endtask

  initial begin
    d4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    d3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    test_reset();
    test_first_push();
    test_full_ovf();
    test_async_reset();
    test_back_to_back();
    test_empty_pop();
    test_depth3_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
